// File: rtl/imem_access_arbiter.sv
// Arbitrates the single-port instruction RAM between the core fetch port and the
// loader/debug port, with window range-check and a pipelined one-cycle response.
//
// rr_last state | meaning
// SIDE_FETCH    | fetch won the last accept; loader wins the next tie
// SIDE_LOADER   | loader won the last accept (or reset); fetch wins the next tie
module imem_access_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 5242880,
  parameter int unsigned AW          = 23
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          f_req_valid,
  input  logic [31:0]   f_req_addr,
  output logic          f_req_ready,
  output logic          f_rsp_valid,
  output logic [31:0]   f_rsp_instr,
  output logic          f_rsp_err,

  input  logic          l_req_valid,
  input  logic          l_req_we,
  input  logic [31:0]   l_req_addr,
  input  logic [31:0]   l_req_wdata,
  input  logic          l_lock,
  output logic          l_req_ready,
  output logic          l_rsp_valid,
  output logic [31:0]   l_rsp_rdata,
  output logic          l_rsp_err,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,

  output logic [15:0]   err_count
);

  typedef enum logic {
    SIDE_FETCH  = 1'b0,
    SIDE_LOADER = 1'b1
  } side_e;

  // 33-bit bounds so a window ending at 2**32 cannot wrap to zero.
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'(DEPTH_WORDS) << 2);

  side_e rr_last, rr_next;

  logic        grant_f, grant_l;
  logic        accept_f, accept_l, accept;
  logic [31:0] sel_addr;
  logic [32:0] addr_ext;
  logic [31:0] word_off;
  logic        addr_ok;
  logic        legal_acc, fault_acc;

  logic        rsp_f_q, rsp_l_q;
  logic        rsp_rd_q, rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= SIDE_LOADER;
    end else begin
      rr_last <= rr_next;
    end
  end

  always_comb begin
    grant_f = 1'b0;
    grant_l = 1'b0;
    rr_next = rr_last;
    if (l_lock) begin
      grant_l = l_req_valid;
    end else if (f_req_valid && l_req_valid) begin
      if (rr_last == SIDE_LOADER) grant_f = 1'b1;
      else                        grant_l = 1'b1;
    end else begin
      grant_f = f_req_valid;
      grant_l = l_req_valid;
    end
    if (grant_f)      rr_next = SIDE_FETCH;
    else if (grant_l) rr_next = SIDE_LOADER;
  end

  // Nothing is accepted while reset is held, so every output stays low.
  assign accept_f = grant_f & rst_n;
  assign accept_l = grant_l & rst_n;
  assign accept   = accept_f | accept_l;

  assign f_req_ready = accept_f;
  assign l_req_ready = accept_l;

  assign sel_addr = grant_l ? l_req_addr : f_req_addr;
  assign addr_ext = {1'b0, sel_addr};
  assign word_off = sel_addr - BASE_ADDR;
  assign addr_ok  = (sel_addr[1:0] == 2'b00) && (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);

  assign legal_acc = accept & addr_ok;
  assign fault_acc = accept & ~addr_ok;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (legal_acc) begin
      mem_en   = 1'b1;
      mem_addr = AW'(word_off >> 2);
      if (accept_l) begin
        mem_we    = l_req_we;
        mem_wdata = l_req_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_f_q   <= 1'b0;
      rsp_l_q   <= 1'b0;
      rsp_rd_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      rsp_f_q   <= accept_f;
      rsp_l_q   <= accept_l;
      rsp_rd_q  <= legal_acc & ~(accept_l & l_req_we);
      rsp_err_q <= fault_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (fault_acc && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end

  // RAM read data lands in the response cycle, so it is steered combinationally.
  assign f_rsp_valid = rsp_f_q;
  assign f_rsp_err   = rsp_f_q & rsp_err_q;
  assign f_rsp_instr = (rsp_f_q && rsp_rd_q) ? mem_rdata : 32'h0;

  assign l_rsp_valid = rsp_l_q;
  assign l_rsp_err   = rsp_l_q & rsp_err_q;
  assign l_rsp_rdata = (rsp_l_q && rsp_rd_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed scoreboard bench for imem_access_arbiter with a behavioural
// synchronous-read RAM hung off the memory port.
module tb_imem_access_arbiter;

  localparam int AW = 23;

  logic          clk, rst_n;
  logic          f_req_valid, f_req_ready, f_rsp_valid, f_rsp_err;
  logic [31:0]   f_req_addr, f_rsp_instr;
  logic          l_req_valid, l_req_we, l_lock, l_req_ready, l_rsp_valid, l_rsp_err;
  logic [31:0]   l_req_addr, l_req_wdata, l_rsp_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [15:0]   err_count;

  imem_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_rsp_valid(f_rsp_valid), .f_rsp_instr(f_rsp_instr), .f_rsp_err(f_rsp_err),
    .l_req_valid(l_req_valid), .l_req_we(l_req_we), .l_req_addr(l_req_addr),
    .l_req_wdata(l_req_wdata), .l_lock(l_lock), .l_req_ready(l_req_ready),
    .l_rsp_valid(l_rsp_valid), .l_rsp_rdata(l_rsp_rdata), .l_rsp_err(l_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM seen by the DUT
  logic [31:0] ram [int];
  logic [31:0] ram_rd;
  int          ram_idx;
  always @(posedge clk) begin
    if (mem_en) begin
      ram_idx = int'(mem_addr);
      ram_rd  = ram.exists(ram_idx) ? ram[ram_idx] : 32'h0;
      if (mem_we) ram[ram_idx] = mem_wdata;
      mem_rdata <= ram_rd;
    end
  end

  typedef struct {
    bit          is_f;
    logic [31:0] data;
    bit          err;
  } exp_rsp_t;

  exp_rsp_t    exp_q[$];
  logic [31:0] model_mem [int];
  bit          rr_m_loader;
  logic [15:0] err_m;
  int          n_cmp, n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h8000_0000) && (a <= 32'h813F_FFFC);
  endfunction

  function automatic logic [31:0] mread(input int idx);
    return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
  endfunction

  task automatic check_rsp();
    exp_rsp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("f_rsp_valid", f_rsp_valid, e.is_f);
      chk("l_rsp_valid", l_rsp_valid, !e.is_f);
      if (e.is_f) begin
        chk("f_rsp_instr", f_rsp_instr, e.data);
        chk("f_rsp_err", f_rsp_err, e.err);
      end else begin
        chk("l_rsp_rdata", l_rsp_rdata, e.data);
        chk("l_rsp_err", l_rsp_err, e.err);
      end
    end else begin
      chk("f_rsp_valid_idle", f_rsp_valid, 1'b0);
      chk("l_rsp_valid_idle", l_rsp_valid, 1'b0);
    end
  endtask

  // One cycle: present inputs at the falling edge, check the accept, then check
  // the response one cycle later.
  task automatic drive(input bit fv, input logic [31:0] fa, input bit lv, input bit lwe,
                       input logic [31:0] la, input logic [31:0] lwd, input bit lock);
    bit gf, gl, ok;
    logic [31:0] a;
    int idx;
    exp_rsp_t e;
    f_req_valid = fv; f_req_addr = fa;
    l_req_valid = lv; l_req_we = lwe; l_req_addr = la; l_req_wdata = lwd; l_lock = lock;
    #1;
    gf = 1'b0; gl = 1'b0;
    if (lock)          gl = lv;
    else if (fv && lv) begin gf = rr_m_loader; gl = !rr_m_loader; end
    else begin gf = fv; gl = lv; end
    a   = gl ? la : fa;
    ok  = legal(a);
    idx = int'((a - 32'h8000_0000) >> 2);
    chk("f_req_ready", f_req_ready, gf);
    chk("l_req_ready", l_req_ready, gl);
    chk("mem_en", mem_en, (gf || gl) && ok);
    chk("mem_we", mem_we, gl && ok && lwe);
    if ((gf || gl) && ok) chk("mem_addr", mem_addr, idx);
    if (gl && ok && lwe) chk("mem_wdata", mem_wdata, lwd);
    if (gf || gl) begin
      e.is_f = gf;
      e.err  = !ok;
      e.data = (!ok || (gl && lwe)) ? 32'h0 : mread(idx);
      exp_q.push_back(e);
      if (!ok && err_m != 16'hFFFF) err_m = err_m + 16'd1;
    end
    @(posedge clk);
    if (gf) rr_m_loader = 1'b0;
    else if (gl) rr_m_loader = 1'b1;
    if (gl && ok && lwe) model_mem[idx] = lwd;
    @(negedge clk);
    check_rsp();
    chk("err_count", err_count, err_m);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; err_m = 16'h0; rr_m_loader = 1'b1;
    ram[1] = 32'h0050_0093;
    model_mem[1] = 32'h0050_0093;
    rst_n = 1'b0;
    f_req_valid = 1'b1; f_req_addr = 32'h8000_0004;
    l_req_valid = 1'b1; l_req_we = 1'b1; l_req_addr = 32'h8000_0008;
    l_req_wdata = 32'h1234_5678; l_lock = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_f_req_ready", f_req_ready, 1'b0);
    chk("rst_l_req_ready", l_req_ready, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_f_rsp_valid", f_rsp_valid, 1'b0);
    chk("rst_l_rsp_valid", l_rsp_valid, 1'b0);
    chk("rst_err_count", err_count, 0);
    rst_n = 1'b1;

    // single fetch, loader write, fetch of the written word, loader read
    drive(1, 32'h8000_0004, 0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h0, 1, 1, 32'h8000_0010, 32'hDEAD_BEEF, 0);
    drive(1, 32'h8000_0010, 0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h0, 1, 0, 32'h8000_0004, 32'h0, 0);

    // contention without lock: F,L,F,L
    for (int i = 0; i < 4; i++) drive(1, 32'h8000_0004, 1, 0, 32'h8000_0010, 32'h0, 0);

    // lock: loader only, then release grants fetch
    for (int i = 0; i < 3; i++) drive(1, 32'h8000_0004, 1, 0, 32'h8000_0010, 32'h0, 1);
    drive(1, 32'h8000_0004, 1, 0, 32'h8000_0010, 32'h0, 0);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);

    // window edges and faults
    drive(1, 32'h813F_FFFC, 0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h0, 1, 1, 32'h813F_FFFC, 32'hCAFE_F00D, 0);
    drive(1, 32'h813F_FFFC, 0, 0, 32'h0, 32'h0, 0);
    drive(1, 32'h7FFF_FFFC, 0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h0, 1, 1, 32'h8000_0002, 32'h5555_AAAA, 0);
    drive(1, 32'h8140_0000, 0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    chk("err_count_three", err_count, 16'd3);

    // reset pulse right after a fetch accept drops the response
    f_req_valid = 1'b1; f_req_addr = 32'h8000_0008;
    l_req_valid = 1'b0; l_lock = 1'b0;
    #1;
    chk("pre_rst_f_req_ready", f_req_ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_f_rsp_valid", f_rsp_valid, 1'b0);
    chk("mid_rst_f_rsp_instr", f_rsp_instr, 32'h0);
    chk("mid_rst_f_req_ready", f_req_ready, 1'b0);
    chk("mid_rst_mem_en", mem_en, 1'b0);
    chk("mid_rst_err_count", err_count, 16'h0);
    rst_n = 1'b1;
    err_m = 16'h0;
    rr_m_loader = 1'b1;
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    drive(1, 32'h8000_0010, 1, 0, 32'h8000_0004, 32'h0, 0);
    drive(1, 32'h8000_0010, 0, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
